// File: rtl/uartwb_pkg.sv
// Shared opcodes, response codes and parser state encoding for the UART-to-Wishbone command path.
package uartwb_pkg;

  localparam logic [7:0] OPC_RD  = 8'h52;
  localparam logic [7:0] OPC_WR  = 8'h57;
  localparam logic [7:0] RSP_ACK = 8'hAA;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/uart_wb_rsp_serializer.sv
// Response byte serializer: loads a word plus a byte count, emits bytes MSB first over tx_valid/tx_ready.
module uart_wb_rsp_serializer
  import uartwb_pkg::*;
#(
  parameter int DATA_WID = 32,
  parameter int CNT_W    = 3
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                load,
  input  logic [DATA_WID-1:0] load_data,
  input  logic [CNT_W-1:0]    load_cnt,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                last
);

  logic [DATA_WID-1:0] shift_reg;
  logic [CNT_W-1:0]    cnt_reg;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
      tx_valid  <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      cnt_reg   <= load_cnt;
      tx_valid  <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      shift_reg <= shift_reg << 8;
      cnt_reg   <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1))
        tx_valid <= 1'b0;
    end
  end

  // The byte on the wire only moves on an accepted transfer, so it is stable under backpressure.
  assign tx_data = shift_reg[DATA_WID-1 -: 8];
  assign last    = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/uart_wb_cmd_parser.sv
// UART byte-stream command parser driving the Wishbone wrapper; one transaction in flight.
// Optional CMD_TIMEOUT_EN aborts a partial command after TIMEOUT_CYC idle cycles with 0xEE.
module uart_wb_cmd_parser
  import uartwb_pkg::*;
#(
  parameter int ADDR_WID    = 32,
  parameter int DATA_WID    = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                wr,
  output logic                en,
  output logic [ADDR_WID-1:0] addr,
  output logic [DATA_WID-1:0] dout,
  input  logic [DATA_WID-1:0] din,
  input  logic                valid,
  output logic                busy
);

  localparam int ADDR_BYTES = ADDR_WID / 8;
  localparam int DATA_BYTES = DATA_WID / 8;
  localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W      = $clog2(MAX_BYTES) + 1;
  localparam int RSP_CW     = $clog2(DATA_BYTES) + 1;

  state_t               state_reg;
  logic                 opc_wr_reg;
  logic [CNT_W-1:0]     byte_cnt_reg;
  logic                 timeout_hit;
  logic                 rsp_load;
  logic [DATA_WID-1:0]  rsp_data;
  logic [RSP_CW-1:0]    rsp_cnt;
  logic                 rsp_last;
  logic                 rsp_done;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_reg;
  logic            in_field;

  assign in_field    = (state_reg == S_ADDR) || (state_reg == S_DATA);
  assign timeout_hit = in_field && !rx_valid && (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i)
      to_cnt_reg <= '0;
    else if (in_field && !rx_valid && !timeout_hit)
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    else
      to_cnt_reg <= '0;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign busy     = (state_reg != S_IDLE);
  assign rsp_done = tx_valid && tx_ready && rsp_last;

  // Response source: error byte, write ack, or the captured read word.
  always_comb begin
    rsp_load = 1'b0;
    rsp_data = '0;
    rsp_cnt  = '0;
    case (state_reg)
      S_IDLE: if (rx_valid && rx_data != OPC_RD && rx_data != OPC_WR) begin
        rsp_load = 1'b1;
        rsp_data = DATA_WID'(RSP_ERR) << (DATA_WID - 8);
        rsp_cnt  = RSP_CW'(1);
      end
      S_ADDR, S_DATA: if (timeout_hit) begin
        rsp_load = 1'b1;
        rsp_data = DATA_WID'(RSP_ERR) << (DATA_WID - 8);
        rsp_cnt  = RSP_CW'(1);
      end
      S_WAIT: if (valid) begin
        rsp_load = 1'b1;
        rsp_data = opc_wr_reg ? (DATA_WID'(RSP_ACK) << (DATA_WID - 8)) : din;
        rsp_cnt  = opc_wr_reg ? RSP_CW'(1) : RSP_CW'(DATA_BYTES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_reg    <= S_IDLE;
      opc_wr_reg   <= 1'b0;
      byte_cnt_reg <= '0;
      addr         <= '0;
      dout         <= '0;
      en           <= 1'b0;
      wr           <= 1'b0;
    end else begin
      en <= 1'b0;
      case (state_reg)
        S_IDLE: if (rx_valid) begin
          if (rx_data == OPC_RD || rx_data == OPC_WR) begin
            opc_wr_reg   <= (rx_data == OPC_WR);
            byte_cnt_reg <= '0;
            state_reg    <= S_ADDR;
          end else begin
            state_reg <= S_ERR;
          end
        end
        S_ADDR: if (timeout_hit) begin
          state_reg <= S_ERR;
        end else if (rx_valid) begin
          addr         <= (addr << 8) | ADDR_WID'(rx_data);
          byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
          if (byte_cnt_reg == CNT_W'(ADDR_BYTES - 1)) begin
            byte_cnt_reg <= '0;
            if (opc_wr_reg) begin
              state_reg <= S_DATA;
            end else begin
              state_reg <= S_ISSUE;
              en        <= 1'b1;
              wr        <= 1'b0;
            end
          end
        end
        S_DATA: if (timeout_hit) begin
          state_reg <= S_ERR;
        end else if (rx_valid) begin
          dout         <= (dout << 8) | DATA_WID'(rx_data);
          byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
          if (byte_cnt_reg == CNT_W'(DATA_BYTES - 1)) begin
            byte_cnt_reg <= '0;
            state_reg    <= S_ISSUE;
            en           <= 1'b1;
            wr           <= 1'b1;
          end
        end
        S_ISSUE: state_reg <= S_WAIT;
        S_WAIT:  if (valid) state_reg <= S_RESP;
        S_RESP, S_ERR: if (rsp_done) state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  uart_wb_rsp_serializer #(
    .DATA_WID (DATA_WID),
    .CNT_W    (RSP_CW)
  ) u_rsp (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .load      (rsp_load),
    .load_data (rsp_data),
    .load_cnt  (rsp_cnt),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .last      (rsp_last)
  );

endmodule

// File: tb/tb_uart_wb_cmd_parser.sv
// Scoreboard bench for uart_wb_cmd_parser: directed and random commands, wrapper model, TX backpressure.
module tb_uart_wb_cmd_parser;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wr;
  logic        en;
  logic [31:0] addr;
  logic [31:0] dout;
  logic [31:0] din;
  logic        valid;
  logic        busy;

  always #5 clk_i = ~clk_i;

  uart_wb_cmd_parser #(
    .ADDR_WID    (32),
    .DATA_WID    (32),
    .TIMEOUT_CYC (50)
  ) dut (
    .clk_i    (clk_i),
    .nrst_i   (nrst_i),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .wr       (wr),
    .en       (en),
    .addr     (addr),
    .dout     (dout),
    .din      (din),
    .valid    (valid),
    .busy     (busy)
  );

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] r;
  } cmd_t;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_tx[$];
  int n_vec = 0;
  int n_err = 0;
  int stall_fixed = -1;
  int wb_delay_fixed = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Wrapper model: checks each en against the issued command, answers with valid after a delay.
  initial begin : wrapper_model
    cmd_t c;
    int   d;
    valid = 1'b0;
    din   = '0;
    forever begin
      @(negedge clk_i);
      if (nrst_i && en) begin
        if (exp_cmd.size() == 0) begin
          chk("unexpected_en", 32'd1, 32'd0);
        end else begin
          c = exp_cmd.pop_front();
          chk("en_wr", {31'd0, wr}, {31'd0, c.w});
          chk("en_addr", addr, c.a);
          if (c.w) chk("en_dout", dout, c.d);
          @(negedge clk_i);
          chk("en_single", {31'd0, en}, 32'd0);
          d = (wb_delay_fixed > 0) ? wb_delay_fixed : int'($urandom_range(3, 6));
          repeat (d - 1) @(negedge clk_i);
          chk("wait_hold_addr", addr, c.a);
          chk("wait_hold_wr", {31'd0, wr}, {31'd0, c.w});
          if (c.w) begin
            exp_tx.push_back(8'hAA);
            din = $urandom;
          end else begin
            for (int i = 3; i >= 0; i--) exp_tx.push_back(c.r[8*i +: 8]);
            din = c.r;
          end
          valid = 1'b1;
          @(negedge clk_i);
          valid = 1'b0;
          din   = $urandom;
          chk("tx_latency", {31'd0, tx_valid}, 32'd1);
        end
      end
    end
  end

  // TX monitor: applies backpressure, checks hold stability, pops the expected byte on each transfer.
  initial begin : tx_monitor
    logic       stalled;
    logic [7:0] held;
    int         wc;
    int         lim;
    int         stall_rand;
    tx_ready   = 1'b0;
    stalled    = 1'b0;
    held       = '0;
    wc         = 0;
    stall_rand = 0;
    forever begin
      @(negedge clk_i);
      if (!nrst_i) begin
        tx_ready = 1'b0;
        stalled  = 1'b0;
        wc       = 0;
      end else begin
        if (stalled) begin
          chk("tx_hold_data", {24'd0, tx_data}, {24'd0, held});
          chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
        end
        if (tx_valid) begin
          lim = (stall_fixed >= 0) ? stall_fixed : stall_rand;
          if (wc < lim) begin
            tx_ready = 1'b0;
            wc++;
            stalled = 1'b1;
            held    = tx_data;
          end else begin
            tx_ready   = 1'b1;
            stalled    = 1'b0;
            wc         = 0;
            stall_rand = int'($urandom_range(0, 2));
            if (exp_tx.size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL unexpected_tx: got %h expected no byte", tx_data);
            end else begin
              chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
          end
        end else begin
          tx_ready = 1'b0;
          stalled  = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_i);
    rx_valid = 1'b0;
    rx_data  = $urandom;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(negedge clk_i);
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] r, input bit junk);
    cmd_t c;
    logic [7:0] opc;
    c.w = w; c.a = a; c.d = d; c.r = r;
    exp_cmd.push_back(c);
    opc = w ? 8'h57 : 8'h52;
    send_byte(opc);
    for (int i = 3; i >= 0; i--) begin gap(); send_byte(a[8*i +: 8]); end
    if (w) for (int i = 3; i >= 0; i--) begin gap(); send_byte(d[8*i +: 8]); end
    chk("en_latency", {31'd0, en}, 32'd1);
    if (junk) begin
      send_byte(8'h52);
      send_byte(8'h57);
    end
    $display("cmd %s addr=%h data=%h rsp=%h", w ? "WR" : "RD", a, d, r);
  endtask

  task automatic send_bad(input logic [7:0] b);
    exp_tx.push_back(8'hEE);
    send_byte(b);
    $display("bad opcode %h", b);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      if (exp_tx.size() == 0 && exp_cmd.size() == 0 && !busy && !valid) break;
      @(negedge clk_i);
    end
    if (k == 3000) chk("idle_timeout", 32'd0, 32'd1);
    else chk("idle_tx_valid", {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_en"}, {31'd0, en}, 32'd0);
    chk({tag, "_wr"}, {31'd0, wr}, 32'd0);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    chk({tag, "_addr"}, addr, 32'd0);
    chk({tag, "_dout"}, dout, 32'd0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] b;
    int kind;
    bit quiet;
    nrst_i   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    #12;
    chk_reset_outputs("por");
    @(negedge clk_i);
    nrst_i = 1'b1;
    @(negedge clk_i);

    wb_delay_fixed = 3;
    stall_fixed    = 0;
    send_cmd(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, $urandom, 1'b0);
    wait_idle();
    send_cmd(1'b0, 32'h0000_0008, 32'h0, 32'h1234_5678, 1'b0);
    wait_idle();
    stall_fixed = 5;
    send_cmd(1'b0, 32'h0000_0008, 32'h0, 32'h1234_5678, 1'b0);
    wait_idle();
    stall_fixed = -1;
    wb_delay_fixed = -1;

    send_bad(8'h41);
    wait_idle();
    send_cmd(1'b0, 32'hCAFE_0010, 32'h0, 32'h9ABC_DEF0, 1'b0);
    wait_idle();

    // Reset in the middle of an address field.
    send_byte(8'h57);
    send_byte(8'h12);
    send_byte(8'h34);
    #2 nrst_i = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    @(negedge clk_i);
    nrst_i = 1'b1;
    @(negedge clk_i);
    send_cmd(1'b1, 32'h8000_0040, 32'h0BAD_F00D, $urandom, 1'b0);
    wait_idle();

    // Opcode-looking bytes arriving while a command is in flight are dropped.
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_5A5A, 1'b1);
    wait_idle();

`ifdef CMD_TIMEOUT_EN
    exp_tx.push_back(8'hEE);
    send_byte(8'h57);
    send_byte(8'h00);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk_i);
      if (tx_valid) quiet = 1'b0;
    end
    chk("timeout_not_early", {31'd0, quiet}, 32'd1);
    wait_idle();
    $display("timeout abort");
`endif

    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        b = $urandom;
        while (b == 8'h52 || b == 8'h57) b = $urandom;
        send_bad(b);
      end else begin
        send_cmd(kind >= 4, $urandom, $urandom, $urandom, $urandom_range(0, 1) == 1);
      end
      wait_idle();
    end

    chk("queues_empty", exp_tx.size() + exp_cmd.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_wb_cmd_parser.md
Name: uart_wb_cmd_parser

Overview:
Command front end between the UART byte receiver/transmitter and the Wishbone master wrapper in the uartwb path. Assembles host byte streams into read/write commands and issues one single-cycle `en` pulse per command on the wrapper interface. Waits for the wrapper's `valid`, then serialises the response back to the UART TX. One transaction in flight at a time.

Parameters:
ADDR_WID, 32, address width; multiple of 8; bytes sent MSB first.
DATA_WID, 32, data width; multiple of 8; bytes sent MSB first.
TIMEOUT_CYC, 1000000, inter-byte timeout in clk_i cycles; used only with CMD_TIMEOUT_EN.

Ports:
clk_i  in  1  system clock
nrst_i  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data valid
tx_data  out  8  response byte to UART TX
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  TX can accept; transfer when tx_valid && tx_ready
wr  out  1  to wrapper: 1 = write, 0 = read
en  out  1  to wrapper: one-cycle command strobe
addr  out  ADDR_WID  to wrapper: address
dout  out  DATA_WID  to wrapper: write data
din  in  DATA_WID  from wrapper: read data
valid  in  1  from wrapper: one-cycle completion strobe (reads and writes)
busy  out  1  high in any state other than S_IDLE

Behaviour:
- Reset: one clock clk_i; reset is asynchronous, active-low on nrst_i.
  - All outputs are 0 and all registers are cleared.
  - State returns to S_IDLE immediately, including mid-command or mid-response.
  - A partial command is lost. No response byte is sent.
- Protocol:
  - Opcode byte: 0x52 = read, 0x57 = write.
  - Then ADDR_WID/8 address bytes.
  - For a write, then DATA_WID/8 data bytes.
  - All multi-byte fields are MSB first.
- States:
  - S_IDLE: on rx_valid with opcode 0x52 or 0x57, latch the opcode, clear the byte counter, go to S_ADDR. On any other byte, go to S_ERR.
  - S_ADDR: each rx_valid shifts the byte into addr (addr <= {addr[ADDR_WID-9:0], rx_data}). After the last address byte: write goes to S_DATA, read goes to S_ISSUE.
  - S_DATA: the same shifting is applied into dout. After the last data byte, go to S_ISSUE.
  - S_ISSUE: en=1 for exactly one cycle, with wr = (opcode==0x57). addr and dout are already stable. Next state is S_WAIT.
  - S_WAIT: hold addr, dout and wr. On valid, latch din into the response shift register (read) or load 0xAA (write), then go to S_RESP. No timeout here; the wrapper always completes.
  - S_RESP: drive tx_valid with the current byte. On tx_ready, advance to the next byte. After the last byte (DATA_WID/8 bytes for a read, 1 byte for a write), go to S_IDLE. tx_data must not change while tx_valid && !tx_ready.
  - S_ERR: send the single byte 0xEE with the same handshake, then go to S_IDLE.
- Dropped bytes: rx_valid in S_ISSUE, S_WAIT, S_RESP or S_ERR is ignored. The host must wait for the response.
- Latency:
  - The last command byte's rx_valid is followed by en one cycle later.
  - The valid cycle is followed by tx_valid one cycle later.
- Byte counter: width is clog2 of max(ADDR_WID, DATA_WID)/8 plus 1. It never wraps within a field.
- en is never asserted outside S_ISSUE. Only one en is issued per command.

Optional Feature:
CMD_TIMEOUT_EN
- Defined: an inter-byte counter runs in S_ADDR and S_DATA and is cleared on each rx_valid. When it reaches TIMEOUT_CYC-1 with no byte received, go to S_ERR and emit 0xEE. The partial command is discarded and no en is issued.
- Undefined: no counter exists. The parser waits indefinitely for the remaining bytes.

Decomposition:
- Package uartwb_pkg holds:
  - OPC_RD=8'h52, OPC_WR=8'h57, RSP_ACK=8'hAA, RSP_ERR=8'hEE
  - the state encoding localparams S_IDLE..S_ERR
- Sub-module uart_wb_rsp_serializer: loads DATA_WID bits plus a byte count and emits bytes MSB first over the tx_valid/tx_ready handshake. The parser FSM instantiates it.

Test Plan:
- Write: send 57 00 00 10 04 DE AD BE EF.
  - Expect one en pulse with wr=1, addr=0x00001004, dout=0xDEADBEEF.
  - Model valid 3 cycles later; expect tx byte 0xAA.
- Read: send 52 00 00 00 08.
  - Expect en with wr=0, addr=0x00000008.
  - Model valid with din=0x12345678; expect tx bytes 12 34 56 78 in order.
- TX backpressure: during the read response, hold tx_ready low for 5 cycles per byte.
  - tx_data must be stable while stalled; the byte order must be unchanged.
- Bad opcode: send 0x41.
  - Expect tx 0xEE, no en, return to idle.
  - A following valid read completes normally.
- Reset: assert nrst_i after 2 address bytes.
  - Outputs go to 0 asynchronously; busy=0.
  - A full write afterwards succeeds.
- With CMD_TIMEOUT_EN and TIMEOUT_CYC=50: send 57 00 then stall.
  - Expect 0xEE after 50 cycles and no en.
  - Bytes received during S_WAIT are ignored.
